// File: rtl/cfg_sector_writer.sv
// Writes the configuration sector (magic, status, trim code) to the EEPROM macro with
// program / wait / read-back / compare per word; magic is invalidated first, restored last.
module cfg_sector_writer #(
  parameter logic [31:0] PRE_DEF_NUM = 32'h3111_1511,
  parameter int unsigned PGM_CYCLES  = 8,
  parameter int unsigned RD_CYCLES   = 16,
  parameter int unsigned TMO_CYCLES  = 4095,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        timer_clk,
  input  logic        por_rst,
  input  logic        wr_req,
  input  logic [7:0]  wr_status,
  input  logic [31:0] wr_tcode,
  output logic        wr_busy,
  output logic        wr_done,
  output logic        wr_err,
  output logic [1:0]  wr_err_code,
  output logic [15:0] ee_addr,
  output logic [31:0] ee_data_l2e,
  output logic        ee_pgm_en,
  output logic        ee_rd_en,
  output logic        ee_vs_en,
  input  logic        ee_busy,
  input  logic [31:0] ee_data_e2l
);

  typedef enum logic [2:0] {IDLE, SETUP, PGM, WAIT, RD, CMP, DONE, ERR} state_t;

  localparam logic [11:0] PGM_LAST  = 12'(PGM_CYCLES - 1);
  localparam logic [11:0] RD_LAST   = 12'(RD_CYCLES - 1);
  localparam logic [11:0] TMO_LAST  = 12'(TMO_CYCLES - 1);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

  state_t      state, next_state;
  logic [11:0] cnt;
  logic [1:0]  idx, next_idx;
  logic [1:0]  retry, next_retry;
  logic [1:0]  next_code;
  logic [7:0]  status_q;
  logic [31:0] tcode_q;
  logic [1:0]  word_addr;
  logic [31:0] word_data;
  logic        accept;

  assign accept = (state == IDLE) && wr_req;

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_retry = retry;
    next_code  = wr_err_code;
    case (state)
      IDLE: begin
        if (wr_req) begin
          next_state = SETUP;
          next_idx   = 2'd0;
          next_retry = 2'd0;
          next_code  = 2'b00;
        end
      end
      SETUP: next_state = PGM;
      PGM: begin
        if (cnt == PGM_LAST) next_state = WAIT;
      end
      WAIT: begin
        if (!ee_busy) begin
          next_state = RD;
        end else if (cnt == TMO_LAST) begin
          next_state = ERR;
          next_code  = 2'b10;
        end
      end
      RD: begin
        if (cnt == RD_LAST) next_state = CMP;
      end
      CMP: begin
        if (ee_data_e2l == ee_data_l2e) begin
          if (idx == 2'd3) begin
            next_state = DONE;
          end else begin
            next_state = SETUP;
            next_idx   = idx + 2'd1;
            next_retry = 2'd0;
          end
        end else if (retry < RETRY_MAX) begin
          next_state = SETUP;
          next_retry = retry + 2'd1;
        end else begin
          next_state = ERR;
          next_code  = 2'b01;
        end
      end
      DONE, ERR: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Address/data of the word about to be programmed; word 1 and 2 use the captured request values.
  always_comb begin
    word_addr = 2'b01;
    word_data = 32'h0;
    case (next_idx)
      2'd0: begin word_addr = 2'b01; word_data = 32'h0; end
      2'd1: begin word_addr = 2'b10; word_data = {24'h0, status_q}; end
      2'd2: begin word_addr = 2'b11; word_data = tcode_q; end
      2'd3: begin word_addr = 2'b01; word_data = PRE_DEF_NUM; end
      default: begin word_addr = 2'b01; word_data = 32'h0; end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge timer_clk) begin
    if (por_rst) begin
      state       <= IDLE;
      cnt         <= 12'd0;
      idx         <= 2'd0;
      retry       <= 2'd0;
      status_q    <= 8'h0;
      tcode_q     <= 32'h0;
      wr_busy     <= 1'b0;
      wr_done     <= 1'b0;
      wr_err      <= 1'b0;
      wr_err_code <= 2'b00;
      ee_addr     <= 16'hFFF0;
      ee_data_l2e <= 32'h0;
      ee_pgm_en   <= 1'b0;
      ee_rd_en    <= 1'b0;
      ee_vs_en    <= 1'b0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      retry <= next_retry;
      cnt   <= (next_state != state) ? 12'd0 : cnt + 12'd1;
      if (accept) begin
        status_q <= wr_status;
        tcode_q  <= wr_tcode;
      end
      if (next_state == SETUP) begin
        ee_addr     <= {12'hFFF, word_addr, 2'b00};
        ee_data_l2e <= word_data;
      end
      wr_busy     <= next_state inside {SETUP, PGM, WAIT, RD, CMP};
      ee_vs_en    <= next_state inside {SETUP, PGM, WAIT, RD, CMP};
      ee_pgm_en   <= (next_state == PGM);
      ee_rd_en    <= (next_state == RD);
      wr_done     <= next_state inside {DONE, ERR};
      wr_err_code <= next_code;
      if (accept)                  wr_err <= 1'b0;
      else if (next_state == ERR)  wr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cfg_sector_writer.sv
// Directed bench for cfg_sector_writer with a small EEPROM model (busy and read-back corruption modes).
module tb_cfg_sector_writer;

  logic        timer_clk = 1'b0;
  logic        por_rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_status = 8'h0;
  logic [31:0] wr_tcode = 32'h0;
  logic        wr_busy, wr_done, wr_err;
  logic [1:0]  wr_err_code;
  logic [15:0] ee_addr;
  logic [31:0] ee_data_l2e;
  logic        ee_pgm_en, ee_rd_en, ee_vs_en;
  logic        ee_busy;
  logic [31:0] ee_data_e2l;

  int checks = 0;
  int errors = 0;
  int viol = 0;

  int busy_mode = 0;
  int corrupt_mode = 0;
  int fffc_cnt = 0;
  int busy_cnt = 0;
  logic pgm_q = 1'b0;
  logic [31:0] mem [4];
  logic [15:0] log_addr [$];
  logic [31:0] log_data [$];

  always #5 timer_clk = ~timer_clk;

  cfg_sector_writer dut (
    .timer_clk   (timer_clk),
    .por_rst     (por_rst),
    .wr_req      (wr_req),
    .wr_status   (wr_status),
    .wr_tcode    (wr_tcode),
    .wr_busy     (wr_busy),
    .wr_done     (wr_done),
    .wr_err      (wr_err),
    .wr_err_code (wr_err_code),
    .ee_addr     (ee_addr),
    .ee_data_l2e (ee_data_l2e),
    .ee_pgm_en   (ee_pgm_en),
    .ee_rd_en    (ee_rd_en),
    .ee_vs_en    (ee_vs_en),
    .ee_busy     (ee_busy),
    .ee_data_e2l (ee_data_e2l)
  );

  // EEPROM model: stores programmed words, logs each program burst, optional busy delay.
  // In delay mode busy is high during PGM and for the first 9 WAIT cycles, so WAIT lasts 10 cycles.
  always @(posedge timer_clk) begin
    pgm_q <= ee_pgm_en;
    if (ee_pgm_en) mem[ee_addr[3:2]] <= ee_data_l2e;
    if (ee_pgm_en && !pgm_q) begin
      log_addr.push_back(ee_addr);
      log_data.push_back(ee_data_l2e);
      if (ee_addr == 16'hFFFC) fffc_cnt = fffc_cnt + 1;
    end
    if (ee_pgm_en) busy_cnt <= 9;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign ee_busy = (busy_mode == 2) || ((busy_mode == 1) && (ee_pgm_en || busy_cnt != 0));
  assign ee_data_e2l = mem[ee_addr[3:2]] ^
    (((ee_addr == 16'hFFFC) && ((corrupt_mode == 2) || (corrupt_mode == 1 && fffc_cnt == 1)))
      ? 32'h0000_0100 : 32'h0);

  always @(negedge timer_clk) begin
    if ((ee_pgm_en && ee_rd_en) || ((ee_pgm_en || ee_rd_en) && !ee_vs_en)) viol = viol + 1;
  end

  // Starts a sequence, scrambles the inputs right after acceptance, and runs until wr_done.
  task automatic run_seq(input logic [7:0] st, input logic [31:0] tc, input int mid_req,
                         input int limit, output int done_cyc, output bit busy_ok);
    int cyc;
    log_addr.delete();
    log_data.delete();
    fffc_cnt = 0;
    done_cyc = -1;
    busy_ok = 1'b1;
    @(negedge timer_clk);
    wr_status = st; wr_tcode = tc; wr_req = 1'b1;
    @(negedge timer_clk);
    wr_req = 1'b0; wr_status = ~st; wr_tcode = ~tc;
    cyc = 1;
    while (cyc <= limit) begin
      if (wr_done) begin
        done_cyc = cyc;
        break;
      end
      if (wr_busy !== 1'b1) busy_ok = 1'b0;
      wr_req = (cyc == mid_req);
      @(negedge timer_clk);
      cyc++;
    end
    wr_req = 1'b0;
  endtask

  task automatic test_reset();
    por_rst = 1'b1;
    repeat (2) @(negedge timer_clk);
    checks++;
    if ({wr_busy, wr_done, wr_err, wr_err_code} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {wr_busy, wr_done, wr_err, wr_err_code});
    end
    checks++;
    if ({ee_pgm_en, ee_rd_en, ee_vs_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 000", {ee_pgm_en, ee_rd_en, ee_vs_en});
    end
    checks++;
    if (ee_addr !== 16'hFFF0 || ee_data_l2e !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h/%h required fff0/00000000", ee_addr, ee_data_l2e);
    end
    por_rst = 1'b0;
    @(negedge timer_clk);
  endtask

  task automatic check_log(input string name, input logic [15:0] ea [4], input logic [31:0] ed [4]);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ga;
      logic [31:0] gd;
      ga = (i < log_addr.size()) ? log_addr[i] : 16'h0;
      gd = (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
      checks++;
      if (ga !== ea[i] || gd !== ed[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got %h<-%h required %h<-%h", name, i, ga, gd, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_ideal();
    int d;
    bit b;
    logic [15:0] ea [4] = '{16'hFFF4, 16'hFFF8, 16'hFFFC, 16'hFFF4};
    logic [31:0] ed [4] = '{32'h0, 32'h9C, 32'h0300_0A5F, 32'h3111_1511};
    run_seq(8'h9C, 32'h0300_0A5F, -1, 200, d, b);
    checks++;
    if (d !== 109) begin errors++; $display("FAIL ideal_done_cycle: got %0d required 109", d); end
    checks++;
    if (b !== 1'b1 || wr_busy !== 1'b0) begin
      errors++; $display("FAIL ideal_busy: busy_ok %0d busy_at_done %0d required 1/0", b, wr_busy);
    end
    checks++;
    if (wr_err !== 1'b0 || wr_err_code !== 2'b00) begin
      errors++; $display("FAIL ideal_err: got %0d/%b required 0/00", wr_err, wr_err_code);
    end
    checks++;
    if (log_addr.size() !== 4) begin
      errors++; $display("FAIL ideal_write_count: got %0d required 4", log_addr.size());
    end
    check_log("ideal", ea, ed);
    wr_req = 1'b1;
    @(negedge timer_clk);
    wr_req = 1'b0;
    checks++;
    if (wr_busy !== 1'b0 || wr_done !== 1'b0) begin
      errors++; $display("FAIL done_cycle_req: busy %0d done %0d required 0/0", wr_busy, wr_done);
    end
    @(negedge timer_clk);
    checks++;
    if (wr_busy !== 1'b0) begin errors++; $display("FAIL done_cycle_req_idle: busy %0d required 0", wr_busy); end
  endtask

  task automatic test_ignore_req();
    int d;
    bit b;
    logic [15:0] ea [4] = '{16'hFFF4, 16'hFFF8, 16'hFFFC, 16'hFFF4};
    logic [31:0] ed [4] = '{32'h0, 32'h5A, 32'h1234_5678, 32'h3111_1511};
    run_seq(8'h5A, 32'h1234_5678, 30, 200, d, b);
    checks++;
    if (d !== 109 || b !== 1'b1) begin
      errors++; $display("FAIL midreq_done: got cycle %0d busy_ok %0d required 109/1", d, b);
    end
    checks++;
    if (log_addr.size() !== 4) begin
      errors++; $display("FAIL midreq_write_count: got %0d required 4", log_addr.size());
    end
    check_log("midreq", ea, ed);
  endtask

  task automatic test_busy_delay();
    int d;
    bit b;
    busy_mode = 1;
    run_seq(8'h9C, 32'h0300_0A5F, -1, 300, d, b);
    busy_mode = 0;
    checks++;
    if (d !== 145 || wr_err !== 1'b0) begin
      errors++; $display("FAIL busy_delay: got cycle %0d err %0d required 145/0", d, wr_err);
    end
  endtask

  task automatic test_retry_once();
    int d;
    bit b;
    corrupt_mode = 1;
    run_seq(8'h9C, 32'h0300_0A5F, -1, 300, d, b);
    corrupt_mode = 0;
    checks++;
    if (d !== 136 || wr_err !== 1'b0) begin
      errors++; $display("FAIL retry_once: got cycle %0d err %0d required 136/0", d, wr_err);
    end
    checks++;
    if (log_addr.size() !== 5 || fffc_cnt !== 2) begin
      errors++; $display("FAIL retry_once_writes: got %0d writes %0d fffc required 5/2", log_addr.size(), fffc_cnt);
    end
  endtask

  task automatic test_retry_fail();
    int d;
    bit b;
    int magic_writes;
    corrupt_mode = 2;
    run_seq(8'h9C, 32'h0300_0A5F, -1, 300, d, b);
    corrupt_mode = 0;
    checks++;
    if (d !== 136 || wr_err !== 1'b1 || wr_err_code !== 2'b01) begin
      errors++; $display("FAIL retry_fail: got cycle %0d err %0d code %b required 136/1/01", d, wr_err, wr_err_code);
    end
    magic_writes = 0;
    foreach (log_addr[i]) if (log_addr[i] == 16'hFFF4 && log_data[i] == 32'h3111_1511) magic_writes++;
    checks++;
    if (magic_writes !== 0 || fffc_cnt !== 3) begin
      errors++; $display("FAIL retry_fail_writes: got magic %0d fffc %0d required 0/3", magic_writes, fffc_cnt);
    end
  endtask

  task automatic test_timeout();
    int d;
    bit b;
    int cyc;
    busy_mode = 2;
    run_seq(8'h9C, 32'h0300_0A5F, -1, 5000, d, b);
    busy_mode = 0;
    checks++;
    if (d !== 4105 || wr_err !== 1'b1 || wr_err_code !== 2'b10) begin
      errors++; $display("FAIL timeout: got cycle %0d err %0d code %b required 4105/1/10", d, wr_err, wr_err_code);
    end
    checks++;
    if ({ee_pgm_en, ee_rd_en, ee_vs_en} !== 3'b000 || log_addr.size() !== 1) begin
      errors++; $display("FAIL timeout_strobes: got %b writes %0d required 000/1", {ee_pgm_en, ee_rd_en, ee_vs_en}, log_addr.size());
    end
    @(negedge timer_clk);
    wr_req = 1'b1;
    @(negedge timer_clk);
    wr_req = 1'b0;
    checks++;
    if (wr_err !== 1'b0 || wr_err_code !== 2'b00) begin
      errors++; $display("FAIL timeout_clear: got err %0d code %b required 0/00", wr_err, wr_err_code);
    end
    cyc = 1;
    while (!wr_done && cyc < 300) begin
      @(negedge timer_clk);
      cyc++;
    end
    checks++;
    if (cyc !== 109 || wr_err !== 1'b0) begin
      errors++; $display("FAIL timeout_recover: got cycle %0d err %0d required 109/0", cyc, wr_err);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge timer_clk);
    wr_status = 8'h9C; wr_tcode = 32'h0300_0A5F; wr_req = 1'b1;
    @(negedge timer_clk);
    wr_req = 1'b0;
    repeat (57) @(negedge timer_clk);
    checks++;
    if (ee_pgm_en !== 1'b1 || ee_addr !== 16'hFFFC) begin
      errors++; $display("FAIL reset_mid_pre: got pgm %0d addr %h required 1/fffc", ee_pgm_en, ee_addr);
    end
    por_rst = 1'b1;
    @(negedge timer_clk);
    por_rst = 1'b0;
    checks++;
    if ({wr_busy, wr_done, wr_err, wr_err_code, ee_pgm_en, ee_rd_en, ee_vs_en} !== 8'b0 ||
        ee_addr !== 16'hFFF0 || ee_data_l2e !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got flags %b addr %h data %h required 00000000/fff0/00000000",
               {wr_busy, wr_done, wr_err, wr_err_code, ee_pgm_en, ee_rd_en, ee_vs_en}, ee_addr, ee_data_l2e);
    end
    @(negedge timer_clk);
    checks++;
    if (wr_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: busy %0d required 0", wr_busy); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_ignore_req();
    test_busy_delay();
    test_retry_once();
    test_retry_fail();
    test_timeout();
    test_reset_mid();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL strobe_invariant: got %0d violations required 0", viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
